// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit_if
// Description : Bundles the redirect inputs, the instruction-memory read
//               handshake and the fetch-queue head port of ifetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_unit_if #(
   parameter int WIDTH  = 16,
   parameter int NREDIR = 4
);
   logic [NREDIR-1:0]       redir_valid;
   logic [NREDIR*WIDTH-1:0] redir_target;
   logic                    imem_read;
   logic [WIDTH-1:0]        imem_address;
   logic                    imem_resp;
   logic [WIDTH-1:0]        imem_rdata;
   logic                    fq_valid;
   logic [WIDTH-1:0]        fq_inst;
   logic [WIDTH-1:0]        fq_pc;
   logic [WIDTH-1:0]        fq_pcplus;
   logic                    fq_ready;

   // Fetch-unit side
   modport master (
      input  redir_valid, redir_target, imem_resp, imem_rdata, fq_ready,
      output imem_read, imem_address, fq_valid, fq_inst, fq_pc, fq_pcplus
   );

   // Memory / decode / redirect-source side
   modport slave (
      output redir_valid, redir_target, imem_resp, imem_rdata, fq_ready,
      input  imem_read, imem_address, fq_valid, fq_inst, fq_pc, fq_pcplus
   );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Fetch stage - PC register, prioritised redirect selection,
//               single-outstanding imem read handshake and a DEPTH-entry
//               fetch queue feeding the IF/ID boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 4,
   parameter int NREDIR   = 4,
   parameter int RESET_PC = 0,
   parameter int PC_INC   = 2
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   ifetch_unit_if.master bus
);
   localparam int                c_ptr_w    = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]  c_depth    = (c_ptr_w+1)'(DEPTH);
   localparam logic [WIDTH-1:0]  c_reset_pc = WIDTH'(RESET_PC);
   localparam logic [WIDTH-1:0]  c_inc      = WIDTH'(PC_INC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_imem_read;
   logic [WIDTH-1:0]     r_pc;
   logic [c_ptr_w:0]     r_count;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [WIDTH-1:0]     r_q_inst   [DEPTH];
   logic [WIDTH-1:0]     r_q_pc     [DEPTH];
   logic [WIDTH-1:0]     r_q_pcplus [DEPTH];

   logic                 w_redir;
   logic [WIDTH-1:0]     w_target;
   logic                 w_push;
   logic                 w_pop;
   logic [c_ptr_w:0]     w_count_next;
   logic                 w_room;

   // Redirect arbitration: scan from the top so the lowest set index wins
   always_comb begin
      w_redir  = 1'b0;
      w_target = '0;
      for (int i = NREDIR-1; i >= 0; i--) begin
         if (bus.redir_valid[i]) begin
            w_redir  = 1'b1;
            w_target = bus.redir_target[i*WIDTH +: WIDTH];
         end
      end
   end

   // A response that coincides with a redirect belongs to the old path
   assign w_push       = (r_state == S_REQ) && bus.imem_resp && !w_redir;
   assign w_pop        = (r_count != '0) && bus.fq_ready;
   assign w_count_next = w_redir ? '0
                       : r_count + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);
   assign w_room       = (w_count_next < c_depth);

   assign bus.imem_read    = r_imem_read;
   assign bus.imem_address = r_pc;
   assign bus.fq_valid     = (r_count != '0);
   assign bus.fq_inst      = r_q_inst[r_rd_ptr];
   assign bus.fq_pc        = r_q_pc[r_rd_ptr];
   assign bus.fq_pcplus    = r_q_pcplus[r_rd_ptr];

   // Fetch FSM and PC: one read outstanding; a killed read is drained in DROP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_imem_read <= 1'b0;
         r_pc        <= c_reset_pc;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_redir) begin
                  r_pc <= w_target;
               end
               if (w_redir || w_room) begin
                  r_state     <= S_REQ;
                  r_imem_read <= 1'b1;
               end
            end
            S_REQ: begin
               if (w_redir) begin
                  r_pc    <= w_target;
                  // Without a response the old read is still in flight
                  r_state <= bus.imem_resp ? S_REQ : S_DROP;
               end else if (bus.imem_resp) begin
                  r_pc <= r_pc + c_inc;
                  if (!w_room) begin
                     r_state     <= S_IDLE;
                     r_imem_read <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               if (w_redir) begin
                  r_pc <= w_target;
               end
               if (bus.imem_resp) begin
                  r_state <= S_REQ;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_imem_read <= 1'b0;
            end
         endcase
      end
   end

   // Fetch queue: circular buffer, flushed by any redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_inst[i]   <= '0;
            r_q_pc[i]     <= '0;
            r_q_pcplus[i] <= '0;
         end
      end else begin
         r_count <= w_count_next;
         if (w_redir) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) begin
               r_q_inst[r_wr_ptr]   <= bus.imem_rdata;
               r_q_pc[r_wr_ptr]     <= r_pc;
               r_q_pcplus[r_wr_ptr] <= r_pc + c_inc;
               r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed, table-driven bench for ifetch_unit with a small
//               instruction-memory responder (immediate or hand-driven).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imm_mode = 1'b1;
   logic        man_resp = 1'b0;
   logic [15:0] man_rdata = '0;
   logic        fq_ready = 1'b1;
   logic [3:0]  redir_valid = '0;
   logic [63:0] redir_target = '0;

   int n_vec = 0;
   int n_err = 0;

   ifetch_unit_if #(.WIDTH(16), .NREDIR(4)) bus ();

   ifetch_unit #(
      .WIDTH(16), .DEPTH(4), .NREDIR(4), .RESET_PC(0), .PC_INC(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model: immediate mode answers in the same cycle with addr^A5A5
   assign bus.imem_resp    = imm_mode ? bus.imem_read : man_resp;
   assign bus.imem_rdata   = imm_mode ? (bus.imem_address ^ 16'hA5A5) : man_rdata;
   assign bus.fq_ready     = fq_ready;
   assign bus.redir_valid  = redir_valid;
   assign bus.redir_target = redir_target;

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic chk1(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b required %b", name, got, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk1 ("rst_imem_read", bus.imem_read, 1'b0);
      chk16("rst_imem_addr", bus.imem_address, 16'h0000);
      chk1 ("rst_fq_valid", bus.fq_valid, 1'b0);
      chk16("rst_fq_inst", bus.fq_inst, 16'h0000);
      chk16("rst_fq_pc", bus.fq_pc, 16'h0000);
      chk16("rst_fq_pcplus", bus.fq_pcplus, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          rst_before;
      bit          ready;
      bit          exp_valid;
      logic [15:0] exp_pc;
      logic [15:0] exp_inst;
      bit          exp_read;
      logic [15:0] exp_addr;
   } vec_t;

   vec_t vecs[15];

   initial begin
      // Streaming with same-cycle responses, decode always ready
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0002};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'hA5A7, 1'b1, 16'h0004};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 16'hA5A1, 1'b1, 16'h0006};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0006, 16'hA5A3, 1'b1, 16'h0008};
      // Decode stalled: fill to 4, stop reading, then drain in order
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0002};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0004};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b1, 16'h0006};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0008};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0008};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'hA5A7, 1'b1, 16'h0008};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0004, 16'hA5A1, 1'b1, 16'h000A};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h0006, 16'hA5A3, 1'b1, 16'h000C};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h0008, 16'hA5AD, 1'b1, 16'h000E};

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].rst_before) do_reset();
         fq_ready = vecs[i].ready;
         tick();
         chk1 ($sformatf("v%0d_fq_valid", i), bus.fq_valid, vecs[i].exp_valid);
         chk1 ($sformatf("v%0d_imem_read", i), bus.imem_read, vecs[i].exp_read);
         chk16($sformatf("v%0d_imem_addr", i), bus.imem_address, vecs[i].exp_addr);
         if (vecs[i].exp_valid) begin
            chk16($sformatf("v%0d_fq_pc", i), bus.fq_pc, vecs[i].exp_pc);
            chk16($sformatf("v%0d_fq_inst", i), bus.fq_inst, vecs[i].exp_inst);
            chk16($sformatf("v%0d_fq_pcplus", i), bus.fq_pcplus, vecs[i].exp_pc + 16'h0002);
         end
      end

      // Delayed response at 0x0004 killed by a redirect to 0x0100
      do_reset();
      imm_mode = 1'b1;
      fq_ready = 1'b1;
      tick();
      tick();
      tick();
      imm_mode = 1'b0;
      man_resp = 1'b0;
      tick();
      chk1 ("dly_read_held", bus.imem_read, 1'b1);
      chk16("dly_addr_held", bus.imem_address, 16'h0004);
      chk1 ("dly_queue_empty", bus.fq_valid, 1'b0);
      tick();
      chk16("dly_addr_held2", bus.imem_address, 16'h0004);
      redir_valid = 4'b0010;
      redir_target[31:16] = 16'h0100;
      tick();
      redir_valid = 4'b0000;
      chk1 ("drop_read_high", bus.imem_read, 1'b1);
      chk16("drop_addr_target", bus.imem_address, 16'h0100);
      man_resp  = 1'b1;
      man_rdata = 16'h1234;
      tick();
      man_resp = 1'b0;
      chk1 ("drop_data_discarded", bus.fq_valid, 1'b0);
      chk16("drop_rereq_addr", bus.imem_address, 16'h0100);
      chk1 ("drop_rereq_read", bus.imem_read, 1'b1);
      imm_mode = 1'b1;
      tick();
      chk1 ("redir_push_valid", bus.fq_valid, 1'b1);
      chk16("redir_push_pc", bus.fq_pc, 16'h0100);
      chk16("redir_push_inst", bus.fq_inst, 16'hA4A5);

      // Two simultaneous redirects with a same-cycle response: index 1 wins
      redir_valid = 4'b0110;
      redir_target[31:16] = 16'h0200;
      redir_target[47:32] = 16'h0300;
      tick();
      redir_valid = 4'b0000;
      chk1 ("prio_flush", bus.fq_valid, 1'b0);
      chk16("prio_pc", bus.imem_address, 16'h0200);
      chk1 ("prio_read", bus.imem_read, 1'b1);
      tick();
      chk16("prio_push_pc", bus.fq_pc, 16'h0200);
      chk16("prio_push_inst", bus.fq_inst, 16'hA7A5);

      // Redirect to the top of the address space: PC wraps to zero
      redir_valid = 4'b0001;
      redir_target[15:0] = 16'hFFFE;
      tick();
      redir_valid = 4'b0000;
      chk1 ("wrap_flush", bus.fq_valid, 1'b0);
      chk16("wrap_addr", bus.imem_address, 16'hFFFE);
      tick();
      chk16("wrap_fq_pc", bus.fq_pc, 16'hFFFE);
      chk16("wrap_fq_pcplus", bus.fq_pcplus, 16'h0000);
      chk16("wrap_fq_inst", bus.fq_inst, 16'h5A5B);
      chk16("wrap_next_addr", bus.imem_address, 16'h0000);
      tick();
      chk16("wrap_next_pc", bus.fq_pc, 16'h0000);
      chk16("wrap_next_inst", bus.fq_inst, 16'hA5A5);

      // Reset asserted while a killed read is being drained
      imm_mode = 1'b0;
      man_resp = 1'b0;
      redir_valid = 4'b1000;
      redir_target[63:48] = 16'h0400;
      tick();
      redir_valid = 4'b0000;
      chk1 ("drop2_read", bus.imem_read, 1'b1);
      chk16("drop2_addr", bus.imem_address, 16'h0400);
      tick();
      chk16("drop2_addr_held", bus.imem_address, 16'h0400);
      do_reset();
      imm_mode = 1'b1;
      tick();
      chk1 ("post_rst_read", bus.imem_read, 1'b1);
      chk16("post_rst_addr", bus.imem_address, 16'h0000);
      tick();
      chk1 ("post_rst_valid", bus.fq_valid, 1'b1);
      chk16("post_rst_pc", bus.fq_pc, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
